// File: rtl/scoot_pkg.sv
// Shared definitions for the scootBot arena: direction indices, FSM states
// and the (x, y) -> cell index mapping used by the arena and its map.
package scoot_pkg;

    localparam int DIR_N      = 0;
    localparam int DIR_E      = 1;
    localparam int DIR_S      = 2;
    localparam int DIR_W      = 3;
    localparam int SENSE_HERE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Row-major cell index: y * width + x
    function automatic int cell_idx(input int x, input int y, input int width);
        return y * width + x;
    endfunction

endpackage

// File: rtl/scoot_arena_if.sv
// Bundle between the map loader / bot side (master) and the arena (slave).
interface scoot_arena_if #(
    parameter int AW = 7,
    parameter int SW = 8
);
    logic          load_we;
    logic [AW-1:0] load_addr;
    logic          load_data;
    logic          start;
    logic [3:0]    move;
    logic [4:0]    sense;
    logic [SW-1:0] pos_x;
    logic [SW-1:0] pos_y;
    logic [SW-1:0] score;
    logic [SW-1:0] steps;
    logic [SW-1:0] items_left;
    logic          running;
    logic          done;

    modport master (
        output load_we, load_addr, load_data, start, move,
        input  sense, pos_x, pos_y, score, steps, items_left, running, done
    );

    modport slave (
        input  load_we, load_addr, load_data, start, move,
        output sense, pos_x, pos_y, score, steps, items_left, running, done
    );
endinterface

// File: rtl/scoot_map.sv
// Item map: one bit per cell, a load write port, a collect clear port,
// a probe read port for the arena's bookkeeping and the five sensor reads.
module scoot_map
    import scoot_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter int HEIGHT = 10,
    parameter int AW     = 7,
    parameter int SW     = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic          i_wr_data,
    input  logic          i_clr_en,
    input  logic [AW-1:0] i_clr_addr,
    input  logic [AW-1:0] i_prb_addr,
    output logic          o_prb,
    input  logic [SW-1:0] i_x,
    input  logic [SW-1:0] i_y,
    output logic [4:0]    o_sense
);
    localparam int CELLS = WIDTH * HEIGHT;

    logic [CELLS-1:0] r_cells;

    // Off-grid coordinates read as empty
    function automatic logic cell_at(input int x, input int y);
        if (x < 0 || x >= WIDTH || y < 0 || y >= HEIGHT)
            return 1'b0;
        return r_cells[AW'(cell_idx(x, y, WIDTH))];
    endfunction

    // Cell storage; clear is applied after write so it wins on a collision
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cells <= '0;
        end else begin
            if (i_wr_en && int'(i_wr_addr) < CELLS)
                r_cells[i_wr_addr] <= i_wr_data;
            if (i_clr_en && int'(i_clr_addr) < CELLS)
                r_cells[i_clr_addr] <= 1'b0;
        end
    end

    // Probe read and neighbour sensing around the registered position
    always_comb begin
        o_prb = 1'b0;
        if (int'(i_prb_addr) < CELLS)
            o_prb = r_cells[i_prb_addr];
        o_sense             = '0;
        o_sense[DIR_N]      = cell_at(int'(i_x), int'(i_y) - 1);
        o_sense[DIR_E]      = cell_at(int'(i_x) + 1, int'(i_y));
        o_sense[DIR_S]      = cell_at(int'(i_x), int'(i_y) + 1);
        o_sense[DIR_W]      = cell_at(int'(i_x) - 1, int'(i_y));
        o_sense[SENSE_HERE] = cell_at(int'(i_x), int'(i_y));
    end
endmodule

// File: rtl/scoot_arena.sv
// Environment for a scootBot: FSM, bot position with edge clamping, score,
// step and item counters. The map itself lives in scoot_map.
module scoot_arena
    import scoot_pkg::*;
#(
    parameter int WIDTH     = 10,
    parameter int HEIGHT    = 10,
    parameter int START_X   = 0,
    parameter int START_Y   = 9,
    parameter int MAX_STEPS = 200,
    parameter int AW        = 7,
    parameter int SW        = 8
) (
    input logic         clk,
    input logic         reset,
    scoot_arena_if.slave bus
);
    localparam int            CELLS      = WIDTH * HEIGHT;
    localparam logic [SW-1:0] X_MAX      = SW'(WIDTH - 1);
    localparam logic [SW-1:0] Y_MAX      = SW'(HEIGHT - 1);
    localparam logic [SW-1:0] X0         = SW'(START_X);
    localparam logic [SW-1:0] Y0         = SW'(START_Y);
    localparam logic [SW-1:0] STEP_LIMIT = SW'(MAX_STEPS);
    localparam logic [AW-1:0] START_ADDR = AW'(cell_idx(START_X, START_Y, WIDTH));

    state_t        r_state, w_state_nxt;
    logic [SW-1:0] r_x, r_y, r_score, r_steps, r_items;
    logic [SW-1:0] w_x_nxt, w_y_nxt, w_score_nxt, w_steps_nxt, w_items_nxt;
    logic [SW-1:0] w_mx, w_my;
    logic [AW-1:0] w_prb_addr;
    logic          w_prb, w_wr_en, w_clr_en, w_addr_ok;
    logic          w_go_n, w_go_e, w_go_s, w_go_w;
    logic [4:0]    w_sense;

    assign w_go_n    = bus.move[DIR_N] & ~bus.move[DIR_S];
    assign w_go_s    = bus.move[DIR_S] & ~bus.move[DIR_N];
    assign w_go_e    = bus.move[DIR_E] & ~bus.move[DIR_W];
    assign w_go_w    = bus.move[DIR_W] & ~bus.move[DIR_E];
    assign w_addr_ok = int'(bus.load_addr) < CELLS;

    // Move target, each axis clamped on its own at the grid edge
    always_comb begin
        w_mx = r_x;
        w_my = r_y;
        if (w_go_e && r_x < X_MAX) w_mx = r_x + SW'(1);
        if (w_go_w && r_x != '0)   w_mx = r_x - SW'(1);
        if (w_go_s && r_y < Y_MAX) w_my = r_y + SW'(1);
        if (w_go_n && r_y != '0)   w_my = r_y - SW'(1);
    end

    // Cell looked at this cycle: move target in RUN, start cell on start, else load address
    always_comb begin
        w_prb_addr = bus.load_addr;
        if (r_state == RUN)
            w_prb_addr = AW'(cell_idx(int'(w_mx), int'(w_my), WIDTH));
        else if (bus.start)
            w_prb_addr = START_ADDR;
    end

    // Next-state and counter updates
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_score_nxt = r_score;
        w_steps_nxt = r_steps;
        w_items_nxt = r_items;
        w_wr_en     = 1'b0;
        w_clr_en    = 1'b0;
        case (r_state)
            RUN: begin
                w_x_nxt     = w_mx;
                w_y_nxt     = w_my;
                w_steps_nxt = r_steps + SW'(1);
                if (w_prb) begin
                    w_clr_en    = 1'b1;
                    w_score_nxt = r_score + SW'(1);
                    w_items_nxt = r_items - SW'(1);
                end
                // Only a collection can empty the map; an empty map runs the full budget
                if ((w_prb && r_items == SW'(1)) || w_steps_nxt == STEP_LIMIT)
                    w_state_nxt = DONE;
            end
            default: begin
                if (bus.start) begin
                    w_state_nxt = RUN;
                    w_x_nxt     = X0;
                    w_y_nxt     = Y0;
                    w_score_nxt = '0;
                    w_steps_nxt = '0;
                    if (w_prb) begin
                        w_clr_en    = 1'b1;
                        w_score_nxt = SW'(1);
                        w_items_nxt = r_items - SW'(1);
                    end
                end else if (r_state == IDLE && bus.load_we && w_addr_ok) begin
                    w_wr_en = 1'b1;
                    if (w_prb != bus.load_data)
                        w_items_nxt = bus.load_data ? r_items + SW'(1) : r_items - SW'(1);
                end
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_x     <= X0;
            r_y     <= Y0;
            r_score <= '0;
            r_steps <= '0;
            r_items <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_score <= w_score_nxt;
            r_steps <= w_steps_nxt;
            r_items <= w_items_nxt;
        end
    end

    scoot_map #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT),
        .AW    (AW),
        .SW    (SW)
    ) u_map (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (bus.load_addr),
        .i_wr_data (bus.load_data),
        .i_clr_en  (w_clr_en),
        .i_clr_addr(w_prb_addr),
        .i_prb_addr(w_prb_addr),
        .o_prb     (w_prb),
        .i_x       (r_x),
        .i_y       (r_y),
        .o_sense   (w_sense)
    );

    assign bus.sense      = w_sense;
    assign bus.pos_x      = r_x;
    assign bus.pos_y      = r_y;
    assign bus.score      = r_score;
    assign bus.steps      = r_steps;
    assign bus.items_left = r_items;
    assign bus.running    = (r_state == RUN);
    assign bus.done       = (r_state == DONE);
endmodule

// File: tb/tb_scoot_arena.sv
// Bench for scoot_arena: a behavioural arena model predicts every output after
// each clock edge; predictions are queued when stimulus is applied and popped
// when the DUT result is sampled.
module tb_scoot_arena;
    import scoot_pkg::*;

    localparam int W  = 10;
    localparam int H  = 10;
    localparam int SX = 0;
    localparam int SY = 9;
    localparam int MS = 200;
    localparam int AW = 7;
    localparam int SW = 8;
    localparam logic [9:0] PAT_ROW = 10'b1001010100;  // items at x = 2, 4, 6, 9

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #250 clk = ~clk;

    scoot_arena_if #(.AW(AW), .SW(SW)) bus();

    scoot_arena #(
        .WIDTH(W), .HEIGHT(H), .START_X(SX), .START_Y(SY),
        .MAX_STEPS(MS), .AW(AW), .SW(SW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int x; int y; int score; int steps; int items; int running; int done; int sense;
    } snap_t;

    snap_t sb_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    bit m_map [W*H];
    int m_x, m_y, m_score, m_steps, m_items, m_st;  // m_st: 0 idle, 1 run, 2 done

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit m_cell(input int x, input int y);
        if (x < 0 || x >= W || y < 0 || y >= H) return 1'b0;
        return m_map[y*W + x];
    endfunction

    function automatic int m_sense();
        return int'({m_cell(m_x, m_y), m_cell(m_x-1, m_y), m_cell(m_x, m_y+1),
                     m_cell(m_x+1, m_y), m_cell(m_x, m_y-1)});
    endfunction

    function automatic int clamp(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_step(input bit rst, input bit we, input int addr, input bit d,
                              input bit st, input logic [3:0] mv);
        int prev;
        if (rst) begin
            foreach (m_map[i]) m_map[i] = 1'b0;
            m_x = SX; m_y = SY; m_score = 0; m_steps = 0; m_items = 0; m_st = 0;
        end else if (m_st == 1) begin
            m_x = clamp(m_x + int'(mv[1]) - int'(mv[3]), W-1);
            m_y = clamp(m_y + int'(mv[2]) - int'(mv[0]), H-1);
            m_steps++;
            prev = m_items;
            if (m_map[m_y*W + m_x]) begin
                m_map[m_y*W + m_x] = 1'b0;
                m_score++;
                m_items--;
            end
            if ((prev != 0 && m_items == 0) || m_steps == MS) m_st = 2;
        end else if (st) begin
            m_x = SX; m_y = SY; m_score = 0; m_steps = 0; m_st = 1;
            if (m_map[SY*W + SX]) begin
                m_map[SY*W + SX] = 1'b0;
                m_score = 1;
                m_items--;
            end
        end else if (m_st == 0 && we && addr < W*H) begin
            if (m_map[addr] != d) m_items += d ? 1 : -1;
            m_map[addr] = d;
        end
    endtask

    task automatic cycle(input bit rst, input bit we, input int addr, input bit d,
                         input bit st, input logic [3:0] mv);
        snap_t e;
        reset         = rst;
        bus.load_we   = we;
        bus.load_addr = AW'(addr);
        bus.load_data = d;
        bus.start     = st;
        bus.move      = mv;
        model_step(rst, we, addr, d, st, mv);
        e.x = m_x; e.y = m_y; e.score = m_score; e.steps = m_steps; e.items = m_items;
        e.running = (m_st == 1) ? 1 : 0;
        e.done    = (m_st == 2) ? 1 : 0;
        e.sense   = m_sense();
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("pos_x", bus.pos_x, e.x);
        check("pos_y", bus.pos_y, e.y);
        check("score", bus.score, e.score);
        check("steps", bus.steps, e.steps);
        check("items_left", bus.items_left, e.items);
        check("running", bus.running, e.running);
        check("done", bus.done, e.done);
        check("sense", bus.sense, e.sense);
    endtask

    task automatic load_pattern();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                cycle(0, 1, y*W + x, PAT_ROW[x], 0, 4'b0000);
    endtask

    // Serpentine sweep: even rows (from the start row) east, odd rows west, north at each end
    function automatic logic [3:0] snake_move();
        if (((SY - m_y) % 2) == 0) return (m_x < W-1) ? 4'b0010 : 4'b0001;
        return (m_x > 0) ? 4'b1000 : 4'b0001;
    endfunction

    initial begin
        int k;
        bus.load_we = 1'b0; bus.load_addr = '0; bus.load_data = 1'b0;
        bus.start = 1'b0; bus.move = 4'b0000;

        // Reset state
        cycle(1, 0, 0, 0, 0, 4'b0000);
        cycle(1, 0, 0, 0, 0, 4'b0000);
        check("rst_pos_y", bus.pos_y, SY);

        // Load bookkeeping: repeated write, clear, out-of-range address
        cycle(0, 1, 5, 1, 0, 4'b0000);
        check("load_w1", bus.items_left, 1);
        cycle(0, 1, 5, 1, 0, 4'b0000);
        check("load_w1_again", bus.items_left, 1);
        cycle(0, 1, 5, 0, 0, 4'b0000);
        check("load_w0", bus.items_left, 0);
        cycle(0, 1, 100, 1, 0, 4'b0000);
        check("load_addr100", bus.items_left, 0);

        // Full sweep over the 40-item pattern
        load_pattern();
        check("pattern_items", bus.items_left, 40);
        cycle(0, 0, 0, 0, 1, 4'b0000);
        k = 0;
        while (bus.done !== 1'b1 && k < 250) begin
            cycle(0, 0, 0, 0, 0, snake_move());
            k++;
        end
        check("sweep_done", bus.done, 1);
        check("sweep_score", bus.score, 40);
        check("sweep_items", bus.items_left, 0);
        check("sweep_under_budget", (bus.steps < MS) ? 1 : 0, 1);

        // Empty map, hold north: clamp at row 0 and run out the step budget
        cycle(1, 0, 0, 0, 0, 4'b0000);
        cycle(0, 0, 0, 0, 1, 4'b0000);
        k = 0;
        while (bus.done !== 1'b1 && k < 260) begin
            cycle(0, 0, 0, 0, 0, 4'b0001);
            k++;
            if (k == 9) check("north_row0", bus.pos_y, 0);
        end
        check("north_steps", bus.steps, MS);
        check("north_y", bus.pos_y, 0);
        check("north_score", bus.score, 0);
        check("north_done", bus.done, 1);

        // Diagonal NE to a single item at (3,6)
        cycle(1, 0, 0, 0, 0, 4'b0000);
        cycle(0, 1, 6*W + 3, 1, 0, 4'b0000);
        cycle(0, 0, 0, 0, 1, 4'b0000);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 4'b0011);
        check("ne_x", bus.pos_x, 3);
        check("ne_y", bus.pos_y, 6);
        check("ne_score", bus.score, 1);
        check("ne_here", bus.sense[SENSE_HERE], 0);
        check("ne_done", bus.done, 1);

        // All four moves cancel; load and start during RUN are ignored
        cycle(1, 0, 0, 0, 0, 4'b0000);
        cycle(0, 1, 0, 1, 0, 4'b0000);
        cycle(0, 0, 0, 0, 1, 4'b0000);
        for (int i = 0; i < 4; i++) cycle(0, 1, 8*W, 1, 1, 4'b1111);
        check("cancel_x", bus.pos_x, 0);
        check("cancel_y", bus.pos_y, 9);
        check("cancel_steps", bus.steps, 4);
        check("cancel_sense_n", bus.sense[DIR_N], 0);
        check("cancel_items", bus.items_left, 1);

        // Reset in the middle of a run
        cycle(1, 0, 0, 0, 0, 4'b0000);
        load_pattern();
        cycle(0, 0, 0, 0, 1, 4'b0000);
        for (int i = 0; i < 50; i++) cycle(0, 0, 0, 0, 0, 4'b0010);
        check("mid_running", bus.running, 1);
        cycle(1, 0, 0, 0, 0, 4'b0010);
        check("midrst_running", bus.running, 0);
        check("midrst_score", bus.score, 0);
        check("midrst_x", bus.pos_x, SX);
        check("midrst_y", bus.pos_y, SY);
        check("midrst_items", bus.items_left, 0);
        check("midrst_sense", bus.sense, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
